// File: rtl/pmem_responder.sv
// pmem_responder
//   Memory-side responder for the core load/store path. Accepts one request
//   at a time, models a fixed LATENCY, performs exactly one pmem_read or
//   pmem_write access per request, then presents the result until consumed.
//
//   The pmem access is served by an internal behavioural backing store of
//   2**MEM_AW 64-bit words indexed by addr[MEM_AW+2:3]. rd_calls, wr_calls and
//   last_wmask record every access; they are not reset, so they survive rst_n
//   and expose exactly which accesses took place.
//
// Ports
//   clk, rst_n       clock, async active-low reset
//   req_valid/ready  request handshake (ready is registered)
//   req_wen          1 = write, 0 = read
//   req_addr         byte address
//   req_wdata        write data
//   req_wmask        byte-lane write mask
//   resp_valid/ready response handshake
//   resp_rdata       read data, 0 for writes
//   resp_is_write    echoes wen of the completed request
module pmem_responder #(
  parameter int LATENCY = 2,
  parameter int MEM_AW  = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_is_write
);

  generate
    if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
      $error("pmem_responder: LATENCY must be 1..255");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic        l_wen;
  logic [63:0] l_addr;
  logic [63:0] l_wdata;
  logic [7:0]  l_wmask;

  logic [63:0] mem [2**MEM_AW];
  logic [31:0] rd_calls;
  logic [31:0] wr_calls;
  logic [7:0]  last_wmask;

  logic              access;
  logic [MEM_AW-1:0] idx;

  // Access fires on the edge that ends the last WAIT cycle.
  assign access = (state == WAIT) && (cnt == 8'd0);
  assign idx    = l_addr[MEM_AW+2:3];

  // Address bits outside the store index and the access statistics are
  // observed by simulation only.
  logic unused_ok;
  assign unused_ok = ^{l_addr[63:MEM_AW+3], l_addr[2:0], rd_calls, wr_calls, last_wmask};

  function automatic logic [63:0] pmem_merge(input logic [63:0] old,
                                             input logic [63:0] wd,
                                             input logic [7:0]  wm);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++)
      if (wm[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= 8'd0;
      req_ready     <= 1'b0;
      resp_valid    <= 1'b0;
      resp_rdata    <= 64'd0;
      resp_is_write <= 1'b0;
      l_wen         <= 1'b0;
      l_addr        <= 64'd0;
      l_wdata       <= 64'd0;
      l_wmask       <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          // req_ready comes up on the first edge out of reset
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            l_wen     <= req_wen;
            l_addr    <= req_addr;
            l_wdata   <= req_wdata;
            l_wmask   <= req_wmask;
            cnt       <= 8'(LATENCY - 1);
            req_ready <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else begin
            resp_rdata    <= l_wen ? 64'd0 : mem[idx];
            resp_is_write <= l_wen;
            resp_valid    <= 1'b1;
            state         <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Backing store; only touched on the access edge, which cannot occur while
  // rst_n holds the control FSM in IDLE.
  always_ff @(posedge clk) begin
    if (access) begin
      if (l_wen) begin
        mem[idx]   <= pmem_merge(mem[idx], l_wdata, l_wmask);
        wr_calls   <= wr_calls + 32'd1;
        last_wmask <= l_wmask;
      end else begin
        rd_calls   <= rd_calls + 32'd1;
      end
    end
  end

endmodule
